mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates an icache-refill read port and a data read/write port onto one memory port.
// Latency : grant on the cycle a request is sampled in IDLE, ack MEM_LAT+1 cycles later.
// Backpress: requesters hold req until ack; one transaction at a time, one IDLE cycle between them.
//
// Ports: clk/rst_n (sync, active-low); i_req/i_addr/i_flush -> i_data/i_ack (instruction side);
//        d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack (data side);
//        mem_addr/mem_we/mem_wdata -> mem_rdata (shared fixed-latency memory port).
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [31:0]       i_data,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int DATA_WID = 32;
    localparam logic [2:0] LAT = 3'(MEM_LAT);

    // Owner encoding: 0 = instruction side, 1 = data side.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                cancel_q, cancel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_WID-1:0] wdata_q, wdata_d;
    logic [DATA_WID-1:0] i_data_q, i_data_d;
    logic [DATA_WID-1:0] d_rdata_q, d_rdata_d;

    logic                i_elig;
    logic                grant_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cancel_d     = cancel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_data_d     = i_data_q;
        d_rdata_d    = d_rdata_q;
        // A flushed fetch is not worth starting.
        i_elig       = i_req & ~i_flush;
        grant_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req || i_elig) begin
                    // D wins if it is alone, or on a tie when I was served last.
                    grant_d      = d_req & (~i_elig | (last_owner_q == OWN_I));
                    owner_d      = grant_d ? OWN_D : OWN_I;
                    last_owner_d = grant_d ? OWN_D : OWN_I;
                    addr_d       = grant_d ? d_addr : i_addr;
                    we_d         = grant_d & d_we;
                    wdata_d      = grant_d ? d_wdata : wdata_q;
                    cnt_d        = LAT;
                    cancel_d     = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = 3'(cnt_q - 3'd1);
                if (owner_q == OWN_I && i_flush) begin
                    cancel_d = 1'b1;
                end
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = mem_rdata;
                        end else if (!(cancel_q || i_flush)) begin
                            i_data_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                cancel_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            cancel_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_data_q     <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cancel_q     <= cancel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_data_q     <= i_data_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // A flush arriving in the DONE cycle itself must still kill the ack.
    assign i_ack     = (state_q == DONE) && (owner_q == OWN_I) && !cancel_q && !i_flush;
    assign d_ack     = (state_q == DONE) && (owner_q == OWN_D);
    // Write strobe only on the first WAIT cycle (counter still at its load value).
    assign mem_we    = (state_q == WAIT) && (cnt_q == LAT) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_data, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, mem_we;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(2), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_data    (i_data),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge (input drive point).
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point of the current cycle.
    task automatic ck();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_flush   = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        ck();
        chk("rst_i_ack", 32'(i_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_i_data", i_data, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);

        // ---- I read only ----
        go(); i_req = 1'b1; i_addr = 32'h40;
        ck(); chk("ird_c0_we", 32'(mem_we), 32'd0);
        go(); ck();
        chk("ird_c1_addr", mem_addr, 32'h40);
        chk("ird_c1_we", 32'(mem_we), 32'd0);
        chk("ird_c1_ack", 32'(i_ack), 32'd0);
        go(); mem_rdata = 32'h0050_0093;
        ck(); chk("ird_c2_ack", 32'(i_ack), 32'd0);
        go(); ck();
        chk("ird_c3_ack", 32'(i_ack), 32'd1);
        chk("ird_c3_data", i_data, 32'h0050_0093);
        chk("ird_c3_we", 32'(mem_we), 32'd0);
        go(); i_req = 1'b0;
        ck();
        chk("ird_c4_state", 32'(dut.state_q), 32'd0);
        chk("ird_c4_ack", 32'(i_ack), 32'd0);
        chk("ird_c4_hold", i_data, 32'h0050_0093);

        // ---- tie after reset: I, then D, then I again ----
        do_reset();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h48; d_addr = 32'h2000;
        mem_rdata = 32'h1111_1111;
        ck();
        go(); ck(); chk("tie_c1_addr_i", mem_addr, 32'h48);
        go();
        go(); ck();
        chk("tie_c3_i_ack", 32'(i_ack), 32'd1);
        chk("tie_c3_d_ack", 32'(d_ack), 32'd0);
        chk("tie_c3_i_data", i_data, 32'h1111_1111);
        go(); i_req = 1'b0; mem_rdata = 32'h2222_2222;
        ck();
        go(); ck(); chk("tie_c5_addr_d", mem_addr, 32'h2000);
        go();
        go(); ck();
        chk("tie_c7_d_ack", 32'(d_ack), 32'd1);
        chk("tie_c7_d_rdata", d_rdata, 32'h2222_2222);
        chk("tie_c7_i_ack", 32'(i_ack), 32'd0);
        go(); i_req = 1'b1; d_req = 1'b1; i_addr = 32'h80; d_addr = 32'h3000;
        mem_rdata = 32'h3333_3333;
        ck();
        go(); ck(); chk("tie2_c9_addr_i", mem_addr, 32'h80);
        go();
        go(); ck();
        chk("tie2_c11_i_ack", 32'(i_ack), 32'd1);
        chk("tie2_c11_i_data", i_data, 32'h3333_3333);
        go(); i_req = 1'b0;
        ck();
        go(); ck(); chk("tie2_c13_addr_d", mem_addr, 32'h3000);
        go();
        go(); ck();
        chk("tie2_c15_d_ack", 32'(d_ack), 32'd1);
        chk("tie2_c15_d_rdata", d_rdata, 32'h3333_3333);
        go(); d_req = 1'b0;
        ck();

        // ---- D write ----
        go(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF;
        ck(); chk("dwr_c0_we", 32'(mem_we), 32'd0);
        go(); ck();
        chk("dwr_c1_we", 32'(mem_we), 32'd1);
        chk("dwr_c1_addr", mem_addr, 32'h1000);
        chk("dwr_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        go(); ck();
        chk("dwr_c2_we", 32'(mem_we), 32'd0);
        go(); ck();
        chk("dwr_c3_d_ack", 32'(d_ack), 32'd1);
        chk("dwr_c3_d_rdata", d_rdata, 32'h3333_3333);
        chk("dwr_c3_we", 32'(mem_we), 32'd0);
        go(); d_req = 1'b0; d_we = 1'b0;
        ck();

        // ---- flush while I transaction in flight ----
        go(); i_req = 1'b1; i_addr = 32'h44;
        ck();
        go(); i_req = 1'b0; i_flush = 1'b1;
        ck();
        go(); i_flush = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        ck(); chk("fl_c2_ack", 32'(i_ack), 32'd0);
        go(); ck();
        chk("fl_c3_ack", 32'(i_ack), 32'd0);
        chk("fl_c3_i_data", i_data, 32'h3333_3333);
        go(); ck();
        chk("fl_c4_state", 32'(dut.state_q), 32'd0);
        chk("fl_c4_i_data", i_data, 32'h3333_3333);

        // ---- flush at request in IDLE: no grant ----
        go(); i_req = 1'b1; i_flush = 1'b1; i_addr = 32'h99;
        ck();
        go(); ck();
        chk("flreq_state", 32'(dut.state_q), 32'd0);
        chk("flreq_addr_hold", mem_addr, 32'h44);
        go(); ck();
        chk("flreq_state2", 32'(dut.state_q), 32'd0);
        i_req = 1'b0; i_flush = 1'b0;

        // ---- reset in the middle of a D read ----
        go(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        ck();
        go(); rst_n = 1'b0; d_req = 1'b0;
        ck(); chk("rstw_c1_state", 32'(dut.state_q), 32'd1);
        go(); ck();
        chk("rstw_c2_d_ack", 32'(d_ack), 32'd0);
        chk("rstw_c2_i_ack", 32'(i_ack), 32'd0);
        chk("rstw_c2_mem_we", 32'(mem_we), 32'd0);
        chk("rstw_c2_mem_addr", mem_addr, 32'd0);
        chk("rstw_c2_mem_wdata", mem_wdata, 32'd0);
        chk("rstw_c2_d_rdata", d_rdata, 32'd0);
        chk("rstw_c2_i_data", i_data, 32'd0);
        chk("rstw_c2_state", 32'(dut.state_q), 32'd0);
        rst_n = 1'b1;
        go(); ck();
        chk("rstw_c3_d_ack", 32'(d_ack), 32'd0);
        chk("rstw_c3_state", 32'(dut.state_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
